gate_pattern_checker: RTL

GATE_PATTERN_CHECKER -- requirements
Module: gate_pattern_checker

---
 rtl/gate_pattern_checker.sv | 122 ++++++++++++
 1 files changed

// File: rtl/gate_pattern_checker.sv
// Exhaustive 4-input pattern checker for a small gate block (x=m&n, y=m|u, z=m^v).
// Optional macro GATE_CHK_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
//
// state     | meaning
// ST_IDLE   | waiting for start, stimulus driven low
// ST_SETTLE | current vector applied, counting SETTLE cycles
// ST_CHECK  | responses sampled and compared against the expected gate values
// ST_DONE   | run complete, results held until next start
module gate_pattern_checker #(
  parameter int SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       m,
  output logic       n,
  output logic       u,
  output logic       v,
  input  logic       x,
  input  logic       y,
  input  logic       z,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [4:0] err_cnt,
  output logic [2:0] fail_vec,
  output logic [3:0] err_idx
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] SETTLE_LD = 3'(SETTLE - 1);

  state_t     state_q, state_d;
  logic [3:0] vec_q, vec_d;
  logic [2:0] cnt_q, cnt_d;
  logic [4:0] err_cnt_q, err_cnt_d;
  logic [2:0] fail_vec_q, fail_vec_d;
  logic [3:0] err_idx_q, err_idx_d;
  logic [2:0] mis;

  // vec bits map to {m,n,u,v}; mismatch flags are ordered {x,y,z}
  assign mis = {x ^ (vec_q[3] & vec_q[2]),
                y ^ (vec_q[3] | vec_q[1]),
                z ^ (vec_q[3] ^ vec_q[0])};

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    err_cnt_d  = err_cnt_q;
    fail_vec_d = fail_vec_q;
    err_idx_d  = err_idx_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d    = ST_SETTLE;
          vec_d      = 4'd0;
          cnt_d      = SETTLE_LD;
          err_cnt_d  = 5'd0;
          fail_vec_d = 3'd0;
          err_idx_d  = 4'd0;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == 3'd0) state_d = ST_CHECK;
        else               cnt_d   = cnt_q - 3'd1;
      end
      ST_CHECK: begin
        if (|mis) begin
          err_cnt_d  = err_cnt_q + 5'd1;
          fail_vec_d = fail_vec_q | mis;
          if (err_cnt_q == 5'd0) err_idx_d = vec_q;
        end
`ifdef GATE_CHK_STOP_ON_FAIL_EN
        if (|mis || vec_q == 4'd15) begin
`else
        if (vec_q == 4'd15) begin
`endif
          state_d = ST_DONE;
        end else begin
          state_d = ST_SETTLE;
          vec_d   = vec_q + 4'd1;
          cnt_d   = SETTLE_LD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_q      <= 4'd0;
      cnt_q      <= 3'd0;
      err_cnt_q  <= 5'd0;
      fail_vec_q <= 3'd0;
      err_idx_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      err_cnt_q  <= err_cnt_d;
      fail_vec_q <= fail_vec_d;
      err_idx_q  <= err_idx_d;
    end
  end

  assign busy         = (state_q == ST_SETTLE) || (state_q == ST_CHECK);
  assign done         = (state_q == ST_DONE);
  assign {m, n, u, v} = busy ? vec_q : 4'd0;
  assign pass         = done && (err_cnt_q == 5'd0);
  assign err_cnt      = err_cnt_q;
  assign fail_vec     = fail_vec_q;
  assign err_idx      = err_idx_q;

endmodule
